// File: rtl/spw_rx_char_decoder.sv
// SpaceWire receive character decoder.
//
// Turns a recovered serial bit stream (one bit per rx_bit_valid strobe, LSB first) into the
// receive status inputs of the link-state FSM. It also delivers decoded N-chars and time codes.
//
// Ports:
//   pclk, reset        system clock, synchronous active-high reset
//   rx_enable          low flushes to HUNT and clears status (data outputs hold)
//   rx_bit_valid       one-cycle strobe qualifying rx_bit
//   rx_bit             received line bit
//   rx_got_bit         registered copy of an accepted rx_bit_valid
//   rx_got_null        level, set on the first NULL since enable
//   rx_got_fct         pulse per FCT that is not part of a NULL
//   rx_got_nchar       pulse per data char, EOP or EEP; rx_nchar_data valid with it
//   rx_nchar_data      [8] = control; data 0x000-0x0FF, EOP 0x100, EEP 0x101
//   rx_got_time_code   pulse per ESC+data; rx_time_out valid with it
//   rx_time_out        last time code received
//   rx_error           sticky parity / escape / disconnect error
//
// Configuration macro: SPW_RX_PARITY_CHECK_EN. When defined, an odd-parity failure sends the
// decoder to ERROR; when undefined, parity is not checked and decoding continues.
//
// Control codes are given in line order (first body bit written first):
// FCT = 0,0  EOP = 0,1  EEP = 1,0  ESC = 1,1.
module spw_rx_char_decoder #(
    parameter int unsigned DISCONNECT_CYCLES = 85
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       rx_bit_valid,
    input  logic       rx_bit,
    output logic       rx_got_bit,
    output logic       rx_got_null,
    output logic       rx_got_fct,
    output logic       rx_got_nchar,
    output logic [8:0] rx_nchar_data,
    output logic       rx_got_time_code,
    output logic [7:0] rx_time_out,
    output logic       rx_error
);

    localparam int unsigned IdleW = $clog2(DISCONNECT_CYCLES + 1);

    typedef enum logic [2:0] {StHunt, StParity, StFlag, StBody, StError} state_e;

    state_e           state_q, state_d;
    logic [5:0]       hunt_q, hunt_d;   // the leading don't-care bit of the NULL is not stored
    logic [6:0]       body_q, body_d;   // eighth body bit is taken straight from rx_bit
    logic             acc_q, acc_d;     // XOR of the previous character's body bits
    logic             par_q, par_d;
    logic             ctrl_q, ctrl_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             esc_q, esc_d;
    logic             armed_q, armed_d;
    logic [IdleW-1:0] idle_q, idle_d;

    logic       got_bit_d, got_null_d, got_fct_d, got_nchar_d, got_tc_d, error_d;
    logic [8:0] nchar_data_d;
    logic [7:0] time_out_d;

    logic [7:0] body_shift;
    logic [1:0] ctrl_code;
    logic       parity_bad;

    assign body_shift = {rx_bit, body_q};
    // Written in line order: first received control bit is the left digit.
    assign ctrl_code  = {body_shift[6], body_shift[7]};

`ifdef SPW_RX_PARITY_CHECK_EN
    assign parity_bad = ~(acc_q ^ par_q ^ rx_bit);
`else
    logic unused_parity;
    assign unused_parity = acc_q ^ par_q;
    assign parity_bad    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        hunt_d       = hunt_q;
        body_d       = body_q;
        acc_d        = acc_q;
        par_d        = par_q;
        ctrl_d       = ctrl_q;
        cnt_d        = cnt_q;
        esc_d        = esc_q;
        armed_d      = armed_q;
        idle_d       = idle_q;
        got_bit_d    = 1'b0;
        got_fct_d    = 1'b0;
        got_nchar_d  = 1'b0;
        got_tc_d     = 1'b0;
        got_null_d   = rx_got_null;
        error_d      = rx_error;
        nchar_data_d = rx_nchar_data;
        time_out_d   = rx_time_out;

        if (!rx_enable) begin
            state_d    = StHunt;
            hunt_d     = '0;
            body_d     = '0;
            acc_d      = 1'b0;
            par_d      = 1'b0;
            ctrl_d     = 1'b0;
            cnt_d      = '0;
            esc_d      = 1'b0;
            armed_d    = 1'b0;
            idle_d     = '0;
            got_null_d = 1'b0;
            error_d    = 1'b0;
        end else if (state_q != StError) begin
            if (rx_bit_valid) begin
                got_bit_d = 1'b1;
                armed_d   = 1'b1;
                idle_d    = '0;
                case (state_q)
                    StHunt: begin
                        hunt_d = {hunt_q[4:0], rx_bit};
                        // ESC (parity ignored) followed by FCT, oldest bit on the left
                        if ({hunt_q, rx_bit} == 7'b1110100) begin
                            got_null_d = 1'b1;
                            acc_d      = 1'b0;
                            state_d    = StParity;
                        end
                    end
                    StParity: begin
                        par_d   = rx_bit;
                        state_d = StFlag;
                    end
                    StFlag: begin
                        if (parity_bad) begin
                            state_d = StError;
                            error_d = 1'b1;
                        end else begin
                            ctrl_d  = rx_bit;
                            cnt_d   = '0;
                            acc_d   = 1'b0;
                            state_d = StBody;
                        end
                    end
                    StBody: begin
                        body_d = body_shift[7:1];
                        acc_d  = acc_q ^ rx_bit;
                        cnt_d  = cnt_q + 3'd1;
                        if (cnt_q == (ctrl_q ? 3'd1 : 3'd7)) begin
                            state_d = StParity;
                            if (ctrl_q) begin
                                case (ctrl_code)
                                    2'b00: begin
                                        if (esc_q) esc_d = 1'b0;   // NULL: no pulse
                                        else       got_fct_d = 1'b1;
                                    end
                                    2'b11: begin
                                        if (esc_q) begin
                                            state_d = StError;
                                            error_d = 1'b1;
                                        end else begin
                                            esc_d = 1'b1;
                                        end
                                    end
                                    default: begin       // EOP / EEP
                                        if (esc_q) begin
                                            state_d = StError;
                                            error_d = 1'b1;
                                        end else begin
                                            got_nchar_d  = 1'b1;
                                            nchar_data_d = {1'b1, 7'd0, ctrl_code == 2'b10};
                                        end
                                    end
                                endcase
                            end else if (esc_q) begin
                                esc_d      = 1'b0;
                                got_tc_d   = 1'b1;
                                time_out_d = body_shift;
                            end else begin
                                got_nchar_d  = 1'b1;
                                nchar_data_d = {1'b0, body_shift};
                            end
                        end
                    end
                    default: ;
                endcase
            end else if (armed_q) begin
                // A bit in the same cycle clears the counter, so only idle cycles count here.
                if (idle_q == IdleW'(DISCONNECT_CYCLES - 1)) begin
                    state_d = StError;
                    error_d = 1'b1;
                end
                if (idle_q != IdleW'(DISCONNECT_CYCLES)) idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q          <= StHunt;
            hunt_q           <= '0;
            body_q           <= '0;
            acc_q            <= 1'b0;
            par_q            <= 1'b0;
            ctrl_q           <= 1'b0;
            cnt_q            <= '0;
            esc_q            <= 1'b0;
            armed_q          <= 1'b0;
            idle_q           <= '0;
            rx_got_bit       <= 1'b0;
            rx_got_null      <= 1'b0;
            rx_got_fct       <= 1'b0;
            rx_got_nchar     <= 1'b0;
            rx_nchar_data    <= '0;
            rx_got_time_code <= 1'b0;
            rx_time_out      <= '0;
            rx_error         <= 1'b0;
        end else begin
            state_q          <= state_d;
            hunt_q           <= hunt_d;
            body_q           <= body_d;
            acc_q            <= acc_d;
            par_q            <= par_d;
            ctrl_q           <= ctrl_d;
            cnt_q            <= cnt_d;
            esc_q            <= esc_d;
            armed_q          <= armed_d;
            idle_q           <= idle_d;
            rx_got_bit       <= got_bit_d;
            rx_got_null      <= got_null_d;
            rx_got_fct       <= got_fct_d;
            rx_got_nchar     <= got_nchar_d;
            rx_nchar_data    <= nchar_data_d;
            rx_got_time_code <= got_tc_d;
            rx_time_out      <= time_out_d;
            rx_error         <= error_d;
        end
    end

endmodule

// File: tb/tb_spw_rx_char_decoder.sv
// Self-checking bench for spw_rx_char_decoder: directed cases plus randomized character
// streams, checked against a character-level model of the receiver.
module tb_spw_rx_char_decoder;

    localparam int unsigned Disc = 85;
`ifdef SPW_RX_PARITY_CHECK_EN
    localparam bit ParChk = 1'b1;
`else
    localparam bit ParChk = 1'b0;
`endif

    localparam int CFct = 0, CEop = 1, CEep = 2, CEsc = 3;

    logic       pclk = 1'b0;
    logic       reset, rx_enable, rx_bit_valid, rx_bit;
    logic       rx_got_bit, rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code, rx_error;
    logic [8:0] rx_nchar_data;
    logic [7:0] rx_time_out;

    always #5 pclk = ~pclk;

    spw_rx_char_decoder #(.DISCONNECT_CYCLES(Disc)) dut (
        .pclk             (pclk),
        .reset            (reset),
        .rx_enable        (rx_enable),
        .rx_bit_valid     (rx_bit_valid),
        .rx_bit           (rx_bit),
        .rx_got_bit       (rx_got_bit),
        .rx_got_null      (rx_got_null),
        .rx_got_fct       (rx_got_fct),
        .rx_got_nchar     (rx_got_nchar),
        .rx_nchar_data    (rx_nchar_data),
        .rx_got_time_code (rx_got_time_code),
        .rx_time_out      (rx_time_out),
        .rx_error         (rx_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Character-level receiver model
    bit         m_null, m_err, m_esc, m_prev_xor;
    logic [8:0] m_nchar;
    logic [7:0] m_time;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit e_bit, input bit e_fct,
                                 input bit e_nchar, input bit e_tc);
        check({tag, " flags"},
              32'({rx_got_bit, rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code, rx_error}),
              32'({e_bit, m_null, e_fct, e_nchar, e_tc, m_err}));
        check({tag, " nchar_data"}, 32'(rx_nchar_data), 32'(m_nchar));
        check({tag, " time_out"}, 32'(rx_time_out), 32'(m_time));
    endtask

    // Called at a falling edge; presents one bit for one cycle and checks the response.
    task automatic send_bit(input logic b, input bit e_bit, input bit e_fct, input bit e_nchar,
                            input bit e_tc, input string tag);
        rx_bit_valid = 1'b1;
        rx_bit       = b;
        @(negedge pclk);
        rx_bit_valid = 1'b0;
        check_outputs(tag, e_bit, e_fct, e_nchar, e_tc);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(negedge pclk);
    endtask

    task automatic flush();
        rx_enable = 1'b0;
        @(negedge pclk);
        rx_enable = 1'b1;
        m_null = 1'b0;
        m_err  = 1'b0;
        m_esc  = 1'b0;
        check_outputs("flush", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Junk bits 0,1,0 then NULL = ESC (P=0) + FCT (P=0).
    task automatic hunt_null();
        logic [10:0] seq;
        seq = 11'b010_0111_0100;
        for (int i = 10; i >= 0; i--) begin
            if (i == 0) m_null = 1'b1;
            send_bit(seq[i], 1'b1, 1'b0, 1'b0, 1'b0, "hunt");
        end
        m_prev_xor = 1'b0;
        m_esc      = 1'b0;
    endtask

    task automatic send_char(input bit is_ctrl, input int code, input logic [7:0] data,
                             input bit bad_par, input string tag);
        logic [7:0] body;
        int         nb;
        logic       p, bx;
        bit         ok, ef, en, et;
        if (is_ctrl) begin
            nb = 2;
            // body[0] is sent first
            case (code)
                CFct:    body = 8'b00;
                CEop:    body = 8'b10;
                CEep:    body = 8'b01;
                default: body = 8'b11;
            endcase
        end else begin
            nb   = 8;
            body = data;
        end
        bx = 1'b0;
        for (int i = 0; i < nb; i++) bx = bx ^ body[i];
        p = ~(is_ctrl ^ m_prev_xor) ^ bad_par;

        send_bit(p, !m_err, 1'b0, 1'b0, 1'b0, {tag, " P"});
        gap();
        ok = !m_err;
        if (ok && bad_par && ParChk) m_err = 1'b1;
        send_bit(is_ctrl, ok, 1'b0, 1'b0, 1'b0, {tag, " C"});
        gap();
        for (int i = 0; i < nb; i++) begin
            ok = !m_err;
            ef = 1'b0;
            en = 1'b0;
            et = 1'b0;
            if (ok && i == nb - 1) begin
                if (!is_ctrl) begin
                    if (m_esc) begin
                        et     = 1'b1;
                        m_time = data;
                        m_esc  = 1'b0;
                    end else begin
                        en      = 1'b1;
                        m_nchar = {1'b0, data};
                    end
                end else if (code == CFct) begin
                    if (m_esc) m_esc = 1'b0;
                    else       ef = 1'b1;
                end else if (m_esc) begin
                    m_err = 1'b1;
                end else if (code == CEsc) begin
                    m_esc = 1'b1;
                end else begin
                    en      = 1'b1;
                    m_nchar = (code == CEop) ? 9'h100 : 9'h101;
                end
            end
            send_bit(body[i], ok, ef, en, et, {tag, " body"});
            gap();
        end
        m_prev_xor = bx;
    endtask

    initial begin
        int r;
        logic [7:0] d;
        reset        = 1'b1;
        rx_enable    = 1'b1;
        rx_bit_valid = 1'b0;
        rx_bit       = 1'b0;
        m_null = 1'b0; m_err = 1'b0; m_esc = 1'b0; m_prev_xor = 1'b0;
        m_nchar = '0;  m_time = '0;
        repeat (3) @(negedge pclk);
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge pclk);

        // NULL, data, EOP, time code
        hunt_null();
        send_char(1'b0, 0, 8'h5A, 1'b0, "data5a");
        send_char(1'b1, CEop, 8'h00, 1'b0, "eop");
        send_char(1'b1, CEep, 8'h00, 1'b0, "eep");
        send_char(1'b1, CFct, 8'h00, 1'b0, "fct");
        send_char(1'b1, CEsc, 8'h00, 1'b0, "esc");
        send_char(1'b0, 0, 8'h3F, 1'b0, "tc3f");
        send_char(1'b1, CEsc, 8'h00, 1'b0, "esc");
        send_char(1'b1, CFct, 8'h00, 1'b0, "null");

        // Bad parity on the second data char
        send_char(1'b0, 0, 8'h11, 1'b0, "data11");
        send_char(1'b0, 0, 8'h22, 1'b1, "badpar");
        send_char(1'b0, 0, 8'h33, 1'b0, "after_badpar");
        flush();

        // Disconnect: not armed before the first bit, then 84 idle ok, 85 idle error
        repeat (100) @(negedge pclk);
        check("unarmed_idle", 32'(rx_error), 32'(0));
        send_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "disc_first");
        repeat (Disc - 1) @(negedge pclk);
        check("idle84", 32'(rx_error), 32'(0));
        send_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "disc_bit84");
        repeat (Disc - 1) @(negedge pclk);
        check("idle84_again", 32'(rx_error), 32'(0));
        @(negedge pclk);
        m_err = 1'b1;
        check_outputs("idle85", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge pclk);
        check("disc_sticky", 32'(rx_error), 32'(1));
        flush();

        // ESC ESC is an escape error; later bits are ignored
        hunt_null();
        send_char(1'b1, CEsc, 8'h00, 1'b0, "esc1");
        send_char(1'b1, CEsc, 8'h00, 1'b0, "esc2");
        send_char(1'b1, CFct, 8'h00, 1'b0, "fct_in_err");
        reset = 1'b1;
        @(negedge pclk);
        reset = 1'b0;
        m_null = 1'b0; m_err = 1'b0; m_esc = 1'b0; m_nchar = '0; m_time = '0;
        check_outputs("reset2", 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized character streams
        for (int t = 0; t < 6; t++) begin
            flush();
            hunt_null();
            for (int c = 0; c < 25; c++) begin
                r = int'($urandom_range(0, 8));
                d = 8'($urandom);
                if (r <= 4) send_char(1'b0, 0, d, ($urandom_range(0, 24) == 0), "rnd_data");
                else        send_char(1'b1, r - 5, 8'h00, ($urandom_range(0, 24) == 0),
                                      "rnd_ctrl");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
